// File: rtl/stage_sequencer.sv
// stage_sequencer: picoMips 4-stage instruction cycle (fetch, decode, execute,
// writeback) with program address generation and stall insertion for
// multi-cycle multiply and the SW[8] user handshake.
// Latency: Stage advances on the edge after Step=1; Addr updates on the 3->0 advance.
// Backpressure: Step is the only advance strobe. It drops for MUL_CYCLES execute
// cycles of a multiply and while blocked on the handshake.
//
// Ports:
//   Clock, Reset        rising-edge clock, asynchronous active-high reset
//   Handshake           raw SW[8] level, asynchronous to Clock
//   WaitHs, MulOp       per-instruction stall requests, valid while Stage=2
//   Branch, BranchAddr  branch request/target, sampled on the Stage-3 advance
//   Addr, Stage         program memory address and current stage
//   Step                combinational advance strobe for write gating
//   Capture             one-cycle pulse: SW[7:0] valid to latch
//   Waiting             high while blocked on the handshake
module stage_sequencer #(
  parameter int ADDR_W      = 5,
  parameter int MUL_CYCLES  = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Handshake,
  input  logic              WaitHs,
  input  logic              MulOp,
  input  logic              Branch,
  input  logic [ADDR_W-1:0] BranchAddr,
  output logic [ADDR_W-1:0] Addr,
  output logic [1:0]        Stage,
  output logic              Step,
  output logic              Capture,
  output logic              Waiting
);

  typedef enum logic [1:0] {
    RUN = 2'd0,
    MUL = 2'd1,
    WH  = 2'd2,
    WL  = 2'd3
  } state_t;

  localparam logic       MUL_EN   = (MUL_CYCLES > 0);
  localparam logic [2:0] MUL_LOAD = MUL_EN ? 3'(MUL_CYCLES - 1) : 3'd0;

  state_t                  state_q, state_d;
  logic [2:0]              cnt_q, cnt_d;
  logic [SYNC_STAGES-1:0]  sync_q;
  logic                    hs;
  logic [1:0]              stage_q;
  logic [ADDR_W-1:0]       addr_q;
  logic                    capture_q, capture_d;
  logic                    waiting_q;
  logic                    step_d;

  // Handshake synchroniser; hs is the last stage.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], Handshake};
    end
  end

  assign hs = sync_q[SYNC_STAGES-1];

  // FSM state, stall counter and registered pulse outputs.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q   <= RUN;
      cnt_q     <= 3'd0;
      capture_q <= 1'b0;
      waiting_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      capture_q <= capture_d;
      waiting_q <= (state_d == WH) || (state_d == WL);
    end
  end

  // Next-state and advance strobe. Only Stage 2 can stall; every other stage
  // advances unconditionally from RUN.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    capture_d = 1'b0;
    step_d    = 1'b0;
    unique case (state_q)
      RUN: begin
        if (stage_q == 2'd2) begin
          // Multiply stall takes priority; a handshake wait follows it.
          if (MulOp && MUL_EN) begin
            state_d = MUL;
            cnt_d   = MUL_LOAD;
          end else if (WaitHs) begin
            state_d = WH;
          end else begin
            step_d = 1'b1;
          end
        end else begin
          step_d = 1'b1;
        end
      end
      MUL: begin
        if (cnt_q != 3'd0) begin
          cnt_d = cnt_q - 3'd1;
        end else if (WaitHs) begin
          state_d = WH;
        end else begin
          state_d = RUN;
          step_d  = 1'b1;
        end
      end
      WH: begin
        if (hs) begin
          state_d   = WL;
          capture_d = 1'b1;
        end
      end
      WL: begin
        // Release only once the switch is back low, so one press frees
        // exactly one waiting instruction.
        step_d = ~hs;
        if (!hs) begin
          state_d = RUN;
        end
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  // Stage counter and program address.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      stage_q <= 2'd0;
      addr_q  <= '0;
    end else if (step_d) begin
      stage_q <= stage_q + 2'd1;
      if (stage_q == 2'd3) begin
        addr_q <= Branch ? BranchAddr : addr_q + ADDR_W'(1);
      end
    end
  end

  assign Addr    = addr_q;
  assign Stage   = stage_q;
  assign Step    = step_d & ~Reset;
  assign Capture = capture_q;
  assign Waiting = waiting_q;

endmodule

// File: tb/tb_stage_sequencer.sv
module tb_stage_sequencer;
  localparam int AW   = 5;
  localparam int MULC = 2;
  localparam int SYNC = 2;
  localparam int NCYC = 4000;

  logic          clk = 1'b0;
  logic          rst;
  logic          hsk;
  logic          wait_hs;
  logic          mul_op;
  logic          branch;
  logic [AW-1:0] baddr;
  logic [AW-1:0] addr;
  logic [1:0]    stage;
  logic          step;
  logic          capture;
  logic          waiting;

  stage_sequencer #(
    .ADDR_W      (AW),
    .MUL_CYCLES  (MULC),
    .SYNC_STAGES (SYNC)
  ) dut (
    .Clock      (clk),
    .Reset      (rst),
    .Handshake  (hsk),
    .WaitHs     (wait_hs),
    .MulOp      (mul_op),
    .Branch     (branch),
    .BranchAddr (baddr),
    .Addr       (addr),
    .Stage      (stage),
    .Step       (step),
    .Capture    (capture),
    .Waiting    (waiting)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: an instruction walks through four stages; in Stage 2 it
  // owes a number of hold cycles (multiply) and optionally a handshake
  // press/release pair. hsq is a delay line of sampled switch levels.
  int m_stage, m_addr, m_hold, m_phase;   // phase: 0 none, 1 await high, 2 await low, 3 done
  bit m_in_s2, m_wait_req, m_cap;
  int hsq[SYNC];

  task automatic model_reset();
    m_stage = 0; m_addr = 0; m_hold = 0; m_phase = 0;
    m_in_s2 = 0; m_wait_req = 0; m_cap = 0;
    for (int i = 0; i < SYNC; i++) hsq[i] = 0;
  endtask

  task automatic model_step(output bit st);
    bit hs_now;
    hs_now = (hsq[SYNC-1] != 0);
    st     = 1'b1;
    m_cap  = 1'b0;
    if (m_stage == 2) begin
      if (!m_in_s2) begin
        m_in_s2    = 1'b1;
        m_hold     = mul_op ? MULC : 0;
        m_wait_req = wait_hs;
        m_phase    = 0;
      end
      if (m_hold > 0) begin
        st = 1'b0;
        m_hold--;
      end else if (m_wait_req && m_phase == 0) begin
        st = 1'b0;
        m_phase = 1;
      end else if (m_phase == 1) begin
        st = 1'b0;
        if (hs_now) begin
          m_phase = 2;
          m_cap   = 1'b1;
        end
      end else if (m_phase == 2) begin
        st = !hs_now;
        if (!hs_now) m_phase = 3;
      end
    end
    if (st) begin
      if (m_stage == 3) m_addr = branch ? int'(baddr) : (m_addr + 1) % (1 << AW);
      if (m_stage == 2) begin
        m_in_s2 = 1'b0;
        m_phase = 0;
      end
      m_stage = (m_stage + 1) % 4;
    end
    for (int i = SYNC - 1; i > 0; i--) hsq[i] = hsq[i-1];
    hsq[0] = int'(hsk);
  endtask

  task automatic check_regs();
    check_eq("addr",    int'(addr),    m_addr);
    check_eq("stage",   int'(stage),   m_stage);
    check_eq("capture", int'(capture), int'(m_cap));
    check_eq("waiting", int'(waiting), (m_phase == 1 || m_phase == 2) ? 1 : 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_addr"},    int'(addr),    0);
    check_eq({tag, "_stage"},   int'(stage),   0);
    check_eq({tag, "_step"},    int'(step),    0);
    check_eq({tag, "_capture"}, int'(capture), 0);
    check_eq({tag, "_waiting"}, int'(waiting), 0);
  endtask

  initial begin
    bit st;
    bit do_rst;
    bit rst_pend;
    int n_wh_rst;
    int n_mul_rst;
    int n_wh_seen;
    int n_mul_seen;
    rst = 1'b1; hsk = 1'b0; wait_hs = 1'b0; mul_op = 1'b0; branch = 1'b0; baddr = '0;
    n_wh_rst = 0; n_mul_rst = 0; n_wh_seen = 0; n_mul_seen = 0;
    model_reset();
    @(posedge clk);
    #1;
    check_reset_outputs("por");
    rst_pend = 1'b1;

    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(negedge clk);
      if (rst_pend) begin
        rst = 1'b0;
        rst_pend = 1'b0;
        model_reset();
      end
      if ($urandom_range(0, 5) == 0) hsk = ~hsk;
      branch = ($urandom_range(0, 3) == 0);
      baddr  = AW'($urandom);
      // Stall requests must stay stable for the whole of Stage 2.
      if (m_stage != 2) begin
        wait_hs = ($urandom_range(0, 2) == 0);
        mul_op  = ($urandom_range(0, 1) == 0);
      end
      #1;
      check_regs();

      // Mid-cycle resets: the first few WH and MUL occurrences are left to
      // complete, the next few are cut short, plus occasional random ones.
      do_rst = 1'b0;
      if (m_phase == 1) begin
        n_wh_seen++;
        if (n_wh_seen > 4 && n_wh_rst < 3) begin
          do_rst = 1'b1;
          n_wh_rst++;
        end
      end else if (m_in_s2 && m_hold > 0) begin
        n_mul_seen++;
        if (n_mul_seen > 4 && n_mul_rst < 3) begin
          do_rst = 1'b1;
          n_mul_rst++;
        end
      end else if ($urandom_range(0, 499) == 0) begin
        do_rst = 1'b1;
      end

      if (do_rst) begin
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs("midrst");
        rst_pend = 1'b1;
      end else begin
        model_step(st);
        check_eq("step", int'(step), int'(st));
      end
    end

    check_eq("wh_resets_done",  n_wh_rst,  3);
    check_eq("mul_resets_done", n_mul_rst, 3);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
